// File: rtl/fan_drive_pkg.sv
// rtl/fan_drive_pkg.sv - shared widths and interlock state encoding for fan_drive
package fan_drive_pkg;

  localparam int LEVEL_W    = 4;
  localparam int PWM_PHASES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COOL = 2'd1,
    HEAT = 2'd2,
    DEAD = 2'd3
  } lock_state_e;

endpackage

// File: rtl/fan_pwm_gen.sv
// rtl/fan_pwm_gen.sv - 16-phase fan PWM with prescaler and period-boundary duty latch
module fan_pwm_gen
  import fan_drive_pkg::*;
#(
  parameter int PWM_PRESCALE = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] duty_in,
  output logic               pwm_out
);

  localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [LEVEL_W-1:0] phase_q, phase_d;
  logic [LEVEL_W-1:0] duty_q, duty_d;
  logic               pwm_q, pwm_d;
  logic               tick;

  always_comb begin
    tick    = (pre_q == PRE_W'(PWM_PRESCALE - 1));
    pre_d   = tick ? '0 : pre_q + 1'b1;
    phase_d = tick ? phase_q + 1'b1 : phase_q;
    // Duty is only sampled as the phase wraps so a period is never split.
    duty_d  = (tick && phase_q == LEVEL_W'(PWM_PHASES - 1)) ? duty_in : duty_q;
    pwm_d   = (phase_q < duty_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q   <= '0;
      phase_q <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/fan_drive.sv
// rtl/fan_drive.sv - heater/cooler interlock, fan level ramp and PWM drive
// Optional kick-start on the 0->1 fan step is enabled by defining FAN_KICKSTART_EN.
module fan_drive
  import fan_drive_pkg::*;
#(
  parameter int PWM_PRESCALE = 4,
  parameter int RAMP_CYCLES  = 8,
  parameter int DEAD_CYCLES  = 3,
  parameter int KICK_CYCLES  = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cooler_req,
  input  logic         heater_req,
  input  logic [3:0]   rps_cmd,
  output logic         cooler_out,
  output logic         heater_out,
  output logic         fan_pwm,
  output logic [3:0]   fan_level,
  output logic         settled,
  output logic         conflict
);

  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam int RAMP_W = $clog2(RAMP_CYCLES + 1);

  lock_state_e        state_q, state_d;
  logic [DEAD_W-1:0]  dead_cnt_q, dead_cnt_d;
  logic [RAMP_W-1:0]  ramp_cnt_q, ramp_cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] target;
  logic [LEVEL_W-1:0] duty_sel;
  logic               cooler_q, cooler_d;
  logic               heater_q, heater_d;
  logic               conflict_q, conflict_d;

  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    case (state_q)
      IDLE: begin
        if (cooler_req && !heater_req)      state_d = COOL;
        else if (heater_req && !cooler_req) state_d = HEAT;
      end
      COOL: begin
        if (!cooler_req || heater_req) begin
          state_d    = DEAD;
          dead_cnt_d = DEAD_W'(DEAD_CYCLES - 1);
        end
      end
      HEAT: begin
        if (!heater_req || cooler_req) begin
          state_d    = DEAD;
          dead_cnt_d = DEAD_W'(DEAD_CYCLES - 1);
        end
      end
      DEAD: begin
        if (dead_cnt_q == '0) state_d = IDLE;
        else                  dead_cnt_d = dead_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    cooler_d   = (state_d == COOL);
    heater_d   = (state_d == HEAT);
    conflict_d = cooler_req & heater_req;
  end

  // Ramp counter keeps running across target changes; direction is chosen at each step.
  always_comb begin
    target     = cooler_req ? rps_cmd : '0;
    ramp_cnt_d = ramp_cnt_q;
    level_d    = level_q;
    if (level_q == target) begin
      ramp_cnt_d = '0;
    end else if (ramp_cnt_q == RAMP_W'(RAMP_CYCLES - 1)) begin
      ramp_cnt_d = '0;
      level_d    = (target > level_q) ? level_q + 1'b1 : level_q - 1'b1;
    end else begin
      ramp_cnt_d = ramp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      dead_cnt_q <= '0;
      ramp_cnt_q <= '0;
      level_q    <= '0;
      cooler_q   <= 1'b0;
      heater_q   <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dead_cnt_q <= dead_cnt_d;
      ramp_cnt_q <= ramp_cnt_d;
      level_q    <= level_d;
      cooler_q   <= cooler_d;
      heater_q   <= heater_d;
      conflict_q <= conflict_d;
    end
  end

`ifdef FAN_KICKSTART_EN
  localparam int KICK_W = $clog2(KICK_CYCLES + 1);

  logic [KICK_W-1:0] kick_cnt_q, kick_cnt_d;

  always_comb begin
    kick_cnt_d = kick_cnt_q;
    if (target == '0)                       kick_cnt_d = '0;
    else if (level_q == '0 && level_d == LEVEL_W'(1)) kick_cnt_d = KICK_W'(KICK_CYCLES);
    else if (kick_cnt_q != '0)              kick_cnt_d = kick_cnt_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) kick_cnt_q <= '0;
    else       kick_cnt_q <= kick_cnt_d;
  end

  assign duty_sel = (kick_cnt_q != '0) ? '1 : level_q;
`else
  logic unused_kick;
  assign unused_kick = (KICK_CYCLES > 0);
  assign duty_sel    = level_q;
`endif

  fan_pwm_gen #(
    .PWM_PRESCALE(PWM_PRESCALE)
  ) u_pwm (
    .clock   (clock),
    .reset   (reset),
    .duty_in (duty_sel),
    .pwm_out (fan_pwm)
  );

  assign cooler_out = cooler_q;
  assign heater_out = heater_q;
  assign conflict   = conflict_q;
  assign fan_level  = level_q;
  assign settled    = (level_q == target);

endmodule

// File: tb/tb_fan_drive.sv
// tb/tb_fan_drive.sv - scoreboard bench for fan_drive with default parameters
module tb_fan_drive;

  localparam int S_COOL  = 0;
  localparam int S_HEAT  = 1;
  localparam int S_PWM   = 2;
  localparam int S_LEVEL = 3;
  localparam int S_SETL  = 4;
  localparam int S_CONF  = 5;
  localparam int S_COUNT = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cooler_req = 1'b0;
  logic       heater_req = 1'b0;
  logic [3:0] rps_cmd = 4'd0;
  logic       cooler_out, heater_out, fan_pwm, settled, conflict;
  logic [3:0] fan_level;

  int n_checks = 0;
  int n_pass   = 0;
  int hi_cnt   = 0;

  string      tag_q[$];
  int         sel_q[$];
  logic [7:0] exp_q[$];

  fan_drive dut (
    .clock      (clock),
    .reset      (reset),
    .cooler_req (cooler_req),
    .heater_req (heater_req),
    .rps_cmd    (rps_cmd),
    .cooler_out (cooler_out),
    .heater_out (heater_out),
    .fan_pwm    (fan_pwm),
    .fan_level  (fan_level),
    .settled    (settled),
    .conflict   (conflict)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic logic [7:0] obs_of(input int sel);
    case (sel)
      S_COOL:  return {7'd0, cooler_out};
      S_HEAT:  return {7'd0, heater_out};
      S_PWM:   return {7'd0, fan_pwm};
      S_LEVEL: return {4'd0, fan_level};
      S_SETL:  return {7'd0, settled};
      S_CONF:  return {7'd0, conflict};
      S_COUNT: return hi_cnt[7:0];
      default: return 8'hxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [7:0] exp);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(exp);
  endtask

  task automatic drain();
    while (tag_q.size() > 0) begin
      string      t;
      int         s;
      logic [7:0] e;
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      check(t, obs_of(s), e);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic count_pwm(input int n);
    hi_cnt = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (fan_pwm) hi_cnt++;
    end
  endtask

  initial begin
    // Reset held two cycles with a live cooler request.
    reset = 1'b1; cooler_req = 1'b1; rps_cmd = 4'd9;
    step(2);
    expect_val("rst_cool", S_COOL, 0);
    expect_val("rst_heat", S_HEAT, 0);
    expect_val("rst_pwm", S_PWM, 0);
    expect_val("rst_level", S_LEVEL, 0);
    expect_val("rst_conf", S_CONF, 0);
    expect_val("rst_settled", S_SETL, 0);
    drain();
    reset = 1'b0;
    step(1);
    expect_val("rel_cool", S_COOL, 1);
    drain();

    // Ramp 0 -> 4; PWM counters restart at this reset edge.
    reset = 1'b1;
    step(1);
    reset = 1'b0; cooler_req = 1'b1; heater_req = 1'b0; rps_cmd = 4'd4;
    step(7);
    expect_val("ramp_e7", S_LEVEL, 0);
    expect_val("ramp_e7_settled", S_SETL, 0);
    drain();
    step(1);
    expect_val("ramp_e8", S_LEVEL, 1);
    drain();
    step(23);
    expect_val("ramp_e31", S_LEVEL, 3);
    drain();
    step(1);
    expect_val("ramp_e32", S_LEVEL, 4);
    expect_val("ramp_e32_settled", S_SETL, 1);
    drain();

    // Duty latched at reset (0) holds until the phase wrap at edge 64.
    count_pwm(32);
    expect_val("pwm_before_wrap", S_COUNT, 0);
    drain();
    step(1);
    expect_val("pwm_first_high", S_PWM, 1);
    drain();
    hi_cnt = 1;
    for (int i = 0; i < 63; i++) begin
      step(1);
      if (fan_pwm) hi_cnt++;
    end
    expect_val("pwm_duty_16of64", S_COUNT, 16);
    expect_val("pwm_settled", S_SETL, 1);
    drain();
    count_pwm(64);
    expect_val("pwm_duty_repeat", S_COUNT, 16);
    drain();

    // Switch COOL -> HEAT in one cycle.
    cooler_req = 1'b0; heater_req = 1'b1;
    step(1);
    expect_val("sw_cool_off", S_COOL, 0);
    expect_val("sw_heat_off0", S_HEAT, 0);
    drain();
    step(3);
    expect_val("sw_heat_off3", S_HEAT, 0);
    expect_val("sw_cool_off3", S_COOL, 0);
    drain();
    step(1);
    expect_val("sw_heat_on", S_HEAT, 1);
    expect_val("sw_level_e5", S_LEVEL, 4);
    drain();
    step(3);
    expect_val("sw_level_e8", S_LEVEL, 3);
    drain();
    step(23);
    expect_val("sw_level_e31", S_LEVEL, 1);
    drain();
    step(1);
    expect_val("sw_level_e32", S_LEVEL, 0);
    expect_val("sw_settled", S_SETL, 1);
    drain();

    // Conflict from IDLE.
    heater_req = 1'b0;
    step(4);
    expect_val("idle_heat", S_HEAT, 0);
    drain();
    cooler_req = 1'b1; heater_req = 1'b1;
    step(1);
    expect_val("conf_flag", S_CONF, 1);
    expect_val("conf_cool", S_COOL, 0);
    expect_val("conf_heat", S_HEAT, 0);
    drain();
    step(2);
    expect_val("conf_hold_cool", S_COOL, 0);
    expect_val("conf_hold_flag", S_CONF, 1);
    drain();
    heater_req = 1'b0;
    step(1);
    expect_val("conf_rel_cool", S_COOL, 1);
    expect_val("conf_rel_flag", S_CONF, 0);
    drain();

    // Reset in the middle of a ramp and of a PWM period.
    reset = 1'b1;
    step(1);
    reset = 1'b0; cooler_req = 1'b1; heater_req = 1'b0; rps_cmd = 4'd3;
    step(24);
    expect_val("mid_level3", S_LEVEL, 3);
    drain();
    step(44);
    expect_val("mid_pwm_high", S_PWM, 1);
    drain();
    rps_cmd = 4'd5;
    step(2);
    reset = 1'b1;
    step(1);
    expect_val("mid_rst_level", S_LEVEL, 0);
    expect_val("mid_rst_pwm", S_PWM, 0);
    expect_val("mid_rst_cool", S_COOL, 0);
    expect_val("mid_rst_settled", S_SETL, 0);
    drain();
    reset = 1'b0;
    step(7);
    expect_val("mid_ramp_e7", S_LEVEL, 0);
    expect_val("mid_cool", S_COOL, 1);
    drain();
    step(1);
    expect_val("mid_ramp_e8", S_LEVEL, 1);
    drain();

    // Reset while in DEAD returns the interlock straight to IDLE.
    cooler_req = 1'b0;
    step(1);
    reset = 1'b1; heater_req = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    expect_val("dead_rst_heat", S_HEAT, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
